// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, feeds the IF/ID register and handles
// stall, branch redirect/flush, end-of-program and misaligned-target faults.
module if_fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 160,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] Inst_Address,
  input  logic [31:0] imem_instruction,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {RUN, DONE, FAULT} state_t;

  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [63:0] if_id_pc_n;
  logic [31:0] if_id_instruction_n;
  logic        if_id_valid_n;
  logic [31:0] fetch_count_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= RUN;
      pc                <= RESET_PC;
      if_id_pc          <= '0;
      if_id_instruction <= NOP_INST;
      if_id_valid       <= 1'b0;
      fetch_count       <= '0;
    end else begin
      state             <= state_n;
      pc                <= pc_n;
      if_id_pc          <= if_id_pc_n;
      if_id_instruction <= if_id_instruction_n;
      if_id_valid       <= if_id_valid_n;
      fetch_count       <= fetch_count_n;
    end
  end

  always_comb begin
    state_n             = state;
    pc_n                = pc;
    if_id_pc_n          = if_id_pc;
    if_id_instruction_n = if_id_instruction;
    if_id_valid_n       = if_id_valid;
    fetch_count_n       = fetch_count;

    if (state == FAULT) begin
      if_id_pc_n          = '0;
      if_id_instruction_n = NOP_INST;
      if_id_valid_n       = 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over stall; the flush happens even for a faulting target.
      if_id_pc_n          = '0;
      if_id_instruction_n = NOP_INST;
      if_id_valid_n       = 1'b0;
      if (branch_target[1:0] != 2'b00) begin
        state_n = FAULT;
      end else begin
        pc_n    = branch_target;
        state_n = (branch_target <= LAST_PC) ? RUN : DONE;
      end
    end else if (stall) begin
      state_n = state;
    end else if (state == RUN && pc <= LAST_PC) begin
      if_id_pc_n          = pc;
      if_id_instruction_n = imem_instruction;
      if_id_valid_n       = 1'b1;
      pc_n                = pc + 64'd4;
      fetch_count_n       = (fetch_count == '1) ? fetch_count : fetch_count + 32'd1;
    end else begin
      state_n             = DONE;
      if_id_pc_n          = '0;
      if_id_instruction_n = NOP_INST;
      if_id_valid_n       = 1'b0;
    end
  end

  assign Inst_Address = pc;
  assign fetch_done   = (state == DONE);
  assign fetch_fault  = (state == FAULT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed test-plan scenarios plus randomized
// stall/redirect traffic, all checked against a behavioural PC/IF-ID model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] Inst_Address;
  logic [31:0] imem_instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        fetch_done;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [64];

  if_fetch_stage #(
    .RESET_PC  (64'd0),
    .IMEM_BYTES(160),
    .NOP_INST  (32'h00000013)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .Inst_Address     (Inst_Address),
    .imem_instruction (imem_instruction),
    .if_id_pc         (if_id_pc),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid),
    .fetch_done       (fetch_done),
    .fetch_fault      (fetch_fault),
    .fetch_count      (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [63:0] addr);
    if (addr < 64'd256) return mem[addr[7:2]];
    return 32'hFFFF_FFFF;
  endfunction

  assign imem_instruction = mem_read(Inst_Address);

  // Behavioural model: PC plus "finished" / "faulted" flags and the IF/ID view.
  logic [63:0] m_pc, m_if_pc;
  logic [31:0] m_inst, m_count;
  logic        m_valid, m_done, m_fault;

  task automatic bubble();
    m_if_pc = '0;
    m_inst  = 32'h00000013;
    m_valid = 1'b0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = '0; m_count = '0; m_done = 0; m_fault = 0;
      bubble();
    end else if (m_fault) begin
      bubble();
    end else if (branch_taken) begin
      bubble();
      if (branch_target % 4 != 0) m_fault = 1;
      else begin
        m_pc   = branch_target;
        m_done = (branch_target > 64'd156);
      end
    end else if (stall) begin
      m_count = m_count;
    end else if (!m_done && m_pc <= 64'd156) begin
      m_if_pc = m_pc;
      m_inst  = mem_read(m_pc);
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    end else begin
      m_done = 1;
      bubble();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("inst_address", Inst_Address, m_pc);
    check("if_id_pc", if_id_pc, m_if_pc);
    check("if_id_instruction", 64'(if_id_instruction), 64'(m_inst));
    check("if_id_valid", 64'(if_id_valid), 64'(m_valid));
    check("fetch_done", 64'(fetch_done), 64'(m_done));
    check("fetch_fault", 64'(fetch_fault), 64'(m_fault));
    check("fetch_count", 64'(fetch_count), 64'(m_count));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] tgt, input logic stl);
    branch_taken = 1'b1; branch_target = tgt; stall = stl;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
  endtask

  logic [63:0] held_pc;

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    for (int unsigned i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h00800593;
    mem[1] = 32'h00000313;
    tick(); tick();
    check("reset_valid", 64'(if_id_valid), 64'd0);
    check("reset_inst", 64'(if_id_instruction), 64'h13);
    check("reset_count", 64'(fetch_count), 64'd0);
    reset_n = 1'b1;

    // Straight-line fetch
    tick();
    check("edge1_pc", if_id_pc, 64'd0);
    check("edge1_inst", 64'(if_id_instruction), 64'h00800593);
    check("edge1_valid", 64'(if_id_valid), 64'd1);
    tick();
    check("edge2_pc", if_id_pc, 64'd4);
    check("edge2_inst", 64'(if_id_instruction), 64'h00000313);
    check("edge2_count", 64'(fetch_count), 64'd2);

    // Stall for three cycles at pc=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", Inst_Address, 64'd8);
      check("stall_if_pc", if_id_pc, 64'd4);
      check("stall_count", 64'(fetch_count), 64'd2);
    end
    stall = 1'b0;
    tick();
    check("resume_pc", if_id_pc, 64'd8);
    check("resume_count", 64'(fetch_count), 64'd3);

    // Redirect with simultaneous stall
    redirect(64'h10, 1'b1);
    check("flush_valid", 64'(if_id_valid), 64'd0);
    check("flush_inst", 64'(if_id_instruction), 64'h13);
    tick();
    check("target_pc", if_id_pc, 64'h10);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = 64'($urandom_range(0, 70)) << 2;
      tick();
    end
    stall = 1'b0; branch_taken = 1'b0;

    // End of program and re-entry
    redirect(64'd148, 1'b0);
    tick(); tick(); tick();
    check("last_pc", if_id_pc, 64'd156);
    check("last_valid", 64'(if_id_valid), 64'd1);
    tick();
    check("done_flag", 64'(fetch_done), 64'd1);
    check("done_addr", Inst_Address, 64'd160);
    check("done_valid", 64'(if_id_valid), 64'd0);
    tick();
    check("done_hold", Inst_Address, 64'd160);
    redirect(64'h44, 1'b0);
    check("reentry_done", 64'(fetch_done), 64'd0);
    tick();
    check("reentry_pc", if_id_pc, 64'h44);

    // Out-of-range aligned target goes straight to DONE
    redirect(64'h200, 1'b0);
    check("far_done", 64'(fetch_done), 64'd1);
    redirect(64'h44, 1'b0);
    tick();

    // Misaligned target
    held_pc = Inst_Address;
    redirect(64'h46, 1'b0);
    check("fault_flag", 64'(fetch_fault), 64'd1);
    check("fault_valid", 64'(if_id_valid), 64'd0);
    check("fault_pc_hold", Inst_Address, held_pc);
    redirect(64'h10, 1'b0);
    check("fault_ignore", Inst_Address, held_pc);
    check("fault_sticky", 64'(fetch_fault), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("fault_cleared", 64'(fetch_fault), 64'd0);
    check("fault_reset_pc", Inst_Address, 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Asynchronous reset mid-run
    redirect(64'h3C, 1'b0);
    tick();
    check("pre_reset_addr", Inst_Address, 64'h40);
    check("pre_reset_valid", 64'(if_id_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_pc", Inst_Address, 64'd0);
    check("async_valid", 64'(if_id_valid), 64'd0);
    check("async_count", 64'(fetch_count), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    stall = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the single-issue RISC-V core. Holds the 64-bit program counter and drives it to the instruction memory as a byte address. Captures the returned 32-bit instruction into the IF/ID pipeline register for the decoder. Handles stall, branch redirect with flush, and end-of-program / misaligned-target termination.

## Interface
- RESET_PC, 64'd0, PC value loaded on reset.
- IMEM_BYTES, 160, instruction-memory size in bytes; the last fetchable PC is IMEM_BYTES-4.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) placed in IF/ID when invalid.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit; hold PC and IF/ID.
- branch_taken  input  1  redirect request from EX.
- branch_target  input  64  redirect byte address.
- Inst_Address  output  64  combinational copy of the PC register, driven to instruction memory.
- imem_instruction  input  32  instruction returned combinationally for Inst_Address.
- if_id_pc  output  64  PC of the registered instruction.
- if_id_instruction  output  32  registered instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_done  output  1  PC ran past IMEM_BYTES; no further fetch.
- fetch_fault  output  1  sticky; misaligned redirect target seen.
- fetch_count  output  32  instructions delivered since reset.

## Operation
- States: RUN, DONE, FAULT. Reset enters RUN.
- Priority each cycle: reset > redirect > stall > normal fetch.
- Redirect (branch_taken=1), any state except FAULT:
  - If branch_target[1:0]!=0: go to FAULT, set fetch_fault, PC unchanged, flush IF/ID.
  - Otherwise: pc <= branch_target; flush IF/ID (valid=0, instruction=NOP_INST, if_id_pc=0).
  - If branch_target <= IMEM_BYTES-4: next state RUN; otherwise DONE.
  - A redirect overrides a simultaneous stall. The flush still happens and fetch_count is not incremented.
- Stall (no redirect): pc, IF/ID, count and state all hold.
- Normal fetch in RUN with pc <= IMEM_BYTES-4:
  - if_id_instruction <= imem_instruction, if_id_pc <= pc, if_id_valid <= 1.
  - pc <= pc+4, with 64-bit wrap.
  - fetch_count <= fetch_count+1, saturating at 32'hFFFFFFFF.
- RUN with pc > IMEM_BYTES-4: go to DONE, load bubble, PC holds.
- In DONE, non-redirect cycles: bubble, PC holds.
- In FAULT: bubble every cycle, PC holds, redirects ignored. Only reset exits FAULT.
- Outputs derived from state:
  - fetch_done = (state==DONE), registered.
  - fetch_fault = (state==FAULT), registered.
- Comparisons are unsigned 64-bit.

## Timing
- Reset values: pc=RESET_PC, if_id_pc=0, if_id_instruction=NOP_INST, if_id_valid=0, fetch_done=0, fetch_fault=0, fetch_count=0, state=RUN.
- Reset is asserted asynchronously; deassertion is synchronised by the caller.
- Reset mid-operation discards any in-flight state immediately.
- Inst_Address equals pc with zero latency; imem_instruction is sampled at the same edge.
- Fetch latency: an instruction at PC p appears on IF/ID one edge after pc==p.
- Branch penalty: a redirect asserted in cycle n gives a bubble at n+1 and the target instruction at n+2.
- fetch_done rises at the edge that sees pc > IMEM_BYTES-4. A pending instruction at IMEM_BYTES-4 is delivered one edge earlier.

## Test plan
- Reset and straight-line fetch:
  - Stimulus: release reset; the memory model returns 0x00800593 at address 0 and 0x00000313 at address 4.
  - Edge 1 response: if_id_pc=0, instruction=0x00800593, valid=1.
  - Edge 2 response: if_id_pc=4, instruction=0x00000313, fetch_count=2.
- Stall:
  - Stimulus: assert stall for 3 cycles at pc=8.
  - Response: Inst_Address stays at 8, IF/ID unchanged, count unchanged; fetch resumes at 8 on the release cycle.
- Redirect with simultaneous stall:
  - Stimulus: branch_taken=1, branch_target=0x10, stall=1.
  - Response: next edge gives valid=0, instruction=0x00000013; the following edge gives if_id_pc=0x10.
- End of program and re-entry:
  - Stimulus: run to pc=156, then to 160.
  - Response: pc=156 is delivered; fetch_done=1 with PC held at 160. A later redirect to 0x44 clears fetch_done and fetches 0x44.
- Misaligned target:
  - Stimulus: redirect to 0x46.
  - Response: fetch_fault=1, valid stays 0. A subsequent redirect to 0x10 is ignored. Only reset_n=0 clears the fault.
- Asynchronous reset mid-run:
  - Stimulus: pull reset_n low between edges while pc=0x40.
  - Response: pc=0, valid=0, count=0 immediately, without waiting for a clock edge.
